// File: rtl/pc_gen_unit_if.sv
// Fetch request bundle between the PC generator (master) and instruction memory (slave).
// The generator drives the request; memory answers with ready and the instruction size.
interface pc_gen_unit_if #(
  parameter int XLEN = 32
) ();
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] pc;
  logic            fetch_compressed;

  modport master (
    output fetch_valid,
    output pc,
    input  fetch_ready,
    input  fetch_compressed
  );

  modport slave (
    input  fetch_valid,
    input  pc,
    output fetch_ready,
    output fetch_compressed
  );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch-stage program counter: picks trap, redirect, sequential step or hold each cycle,
// runs a BOOT/RUN/HALT control state, flags misaligned redirects and counts accepted fetches.
module pc_gen_unit #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int                C_EXT        = 0,
  parameter int                CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_gen_unit_if.master        fetch,
  input  logic                 br_valid,
  input  logic                 br_is_jalr,
  input  logic [XLEN-1:0]      br_pc,
  input  logic [XLEN-1:0]      br_base,
  input  logic [XLEN-1:0]      br_imm,
  output logic [XLEN-1:0]      br_target,
  input  logic                 trap_valid,
  input  logic [XLEN-1:0]      trap_vec,
  input  logic                 halt_req,
  input  logic                 resume_req,
  output logic                 halted,
  output logic                 misalign_exc,
  output logic [XLEN-1:0]      misalign_addr,
  output logic [CNT_W-1:0]     fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   pc_reg, pc_next;
  logic [XLEN-1:0]   misalign_addr_reg, misalign_addr_next;
  logic              misalign_exc_reg, misalign_exc_next;
  logic [CNT_W-1:0]  fetch_count_reg, fetch_count_next;
  logic              fetch_valid;
  logic              accept;
  logic              target_misaligned;
  logic [XLEN-1:0]   step;
  logic [XLEN-1:0]   trap_pc;

  assign br_target = br_is_jalr ? ((br_base + br_imm) & ~XLEN'(1)) : (br_pc + br_imm);
  assign trap_pc   = trap_vec & ~XLEN'(3);
  assign step      = ((C_EXT != 0) && fetch.fetch_compressed) ? XLEN'(2) : XLEN'(4);

  // With compressed support only the byte bit matters; jalr already clears it.
  generate
    if (C_EXT != 0) begin : g_align_c
      assign target_misaligned = br_target[0];
    end else begin : g_align_w
      assign target_misaligned = |br_target[1:0];
    end
  endgenerate

  assign fetch_valid       = (state_reg == RUN);
  assign accept            = fetch_valid & fetch.fetch_ready;
  assign fetch.fetch_valid = fetch_valid;
  assign fetch.pc          = pc_reg;
  assign halted            = (state_reg == HALT);
  assign misalign_exc      = misalign_exc_reg;
  assign misalign_addr     = misalign_addr_reg;
  assign fetch_count       = fetch_count_reg;

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    misalign_exc_next  = 1'b0;
    misalign_addr_next = misalign_addr_reg;
    fetch_count_next   = accept ? fetch_count_reg + CNT_W'(1) : fetch_count_reg;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        if (trap_valid) begin
          pc_next = trap_pc;
        end else if (br_valid && !target_misaligned) begin
          pc_next = br_target;
        end else if (br_valid) begin
          misalign_exc_next  = 1'b1;
          misalign_addr_next = br_target;
        end else if (accept) begin
          pc_next = pc_reg + step;
        end
        if (halt_req) state_next = HALT;
      end
      HALT: begin
        // Redirects are ignored while halted; only traps move the PC.
        if (trap_valid) pc_next = trap_pc;
        if (resume_req) state_next = RUN;
      end
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= BOOT;
      pc_reg            <= RESET_VECTOR;
      misalign_exc_reg  <= 1'b0;
      misalign_addr_reg <= '0;
      fetch_count_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      misalign_exc_reg  <= misalign_exc_next;
      misalign_addr_reg <= misalign_addr_next;
      fetch_count_reg   <= fetch_count_next;
    end
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised program-counter generator for the fetch stage.
- Holds the architectural fetch PC and presents it to instruction memory over a valid/ready handshake.
- Selects the next PC from trap, branch/jump redirect, sequential step (+2/+4) or hold.
- Flags misaligned redirect targets, supports a halt/resume debug state, and counts accepted fetches.

Parameters:
- XLEN, 32, PC and address width.
- RESET_VECTOR, 32'h0000_0000, PC loaded while rst is high.
- C_EXT, 0, 1 = compressed instructions allowed: step may be 2 and 2-byte alignment is legal.
- CNT_W, 32, width of the fetch counter.

Ports:
- clk in 1: rising-edge clock.
- rst in 1: synchronous, active-high reset.
- fetch_valid out 1: PC request valid.
- fetch_ready in 1: IMEM accepts the request.
- pc out XLEN: current fetch PC.
- fetch_compressed in 1: fetched instruction is 16-bit; sampled only on acceptance; ignored when C_EXT=0.
- br_valid in 1: EX-stage redirect request.
- br_is_jalr in 1: 1 = target is br_base+br_imm with bit0 cleared; 0 = target is br_pc+br_imm.
- br_pc in XLEN: PC of the redirecting instruction.
- br_base in XLEN: rs1 value for jalr.
- br_imm in XLEN: sign-extended immediate.
- br_target out XLEN: combinational computed target.
- trap_valid in 1: trap redirect.
- trap_vec in XLEN: trap handler address; bits[1:0] forced to 0.
- halt_req in 1: request entry to HALT.
- resume_req in 1: request exit from HALT.
- halted out 1: state==HALT.
- misalign_exc out 1: registered one-cycle pulse.
- misalign_addr out XLEN: offending target; held until the next pulse.
- fetch_count out CNT_W: accepted-fetch counter.

Behaviour:
- States: BOOT, RUN, HALT.
- Reset (rst=1 at an edge):
  - state=BOOT, pc=RESET_VECTOR, fetch_valid=0, halted=0, misalign_exc=0, misalign_addr=0, fetch_count=0.
  - Reset mid-operation discards every pending request.
- BOOT: exactly one cycle with fetch_valid=0, then RUN.
- RUN:
  - fetch_valid=1.
  - Acceptance is fetch_valid & fetch_ready in the same cycle.
- Arithmetic, all modulo 2^XLEN (wrap-around silent):
  - br_target = br_is_jalr ? ((br_base+br_imm) & ~1) : (br_pc+br_imm).
  - step = (C_EXT && fetch_compressed) ? 2 : 4.
- Next-PC priority in RUN, evaluated each edge:
  1. trap_valid: pc <= trap_vec & ~3.
  2. br_valid with legal target: pc <= br_target.
  3. br_valid with misaligned target: pc held; misalign_exc=1 next cycle; misalign_addr=br_target.
  4. Accepted fetch: pc <= pc+step.
  5. Otherwise pc held.
- Misaligned target definition:
  - C_EXT=0: br_target[1:0]!=0.
  - C_EXT=1: br_target[0]!=0. This is only reachable for the non-jalr form.
- A redirect in the same cycle as an acceptance overrides the sequential step; the accepted fetch is still counted.
- fetch_count increments by 1 on every acceptance in any state and wraps at 2^CNT_W.
- pc is stable while fetch_valid=1 && fetch_ready=0, unless a trap or redirect occurs.
- HALT entry: halt_req in RUN sets state=HALT at the next edge. The pc update of that same edge (trap, branch or step) still applies.
- HALT:
  - fetch_valid=0, halted=1.
  - trap_valid still loads pc; br_valid is ignored and no misalign check is made.
  - resume_req sets RUN at the next edge; fetch resumes at the held pc.
- Simultaneous halt_req and resume_req: in RUN, halt wins; in HALT, resume wins.
- halt_req/resume_req in BOOT are ignored.
- misalign_exc deasserts the cycle after the pulse unless another misaligned redirect occurs.

Test Plan:
- Reset release, RESET_VECTOR=32'h100, fetch_ready=1 → fetch_valid=0 for the BOOT cycle; then pc=100,104,108; fetch_count=3 after 3 accepts.
- C_EXT=1, pc=0x200, fetch_compressed pattern 1,0,1 → pc=0x202, 0x206, 0x208.
- Stall: fetch_ready=0 for 3 cycles at pc=0x40 → pc held at 0x40, count unchanged. Then br_valid with br_pc=0x30, br_imm=0x20 in the same cycle as an accept → pc=0x50, count +1.
- Misalign: C_EXT=0, jalr with base=0x1001, imm=1 → br_target=0x1002, misalign_exc pulses 1 cycle, misalign_addr=0x1002, pc unchanged. Simultaneous trap_valid with trap_vec=0x80000007 → pc=0x80000004.
- Wrap-around and halt: pc=0xFFFFFFFC, accept with halt_req → pc=0x0, halted=1, fetch_valid=0. br_valid while halted is ignored; resume_req → fetch at 0x0 next cycle.
- rst asserted while in HALT with a misalign pulse pending → all outputs return to reset values on the next edge.
